multicycle_control32: RTL
=========================

// Module: multicycle_control32
// PURPOSE
//  Multi-cycle successor to the single-cycle MIPS decoder. It decodes the held IR fields into the same
//  datapath selects and sequences each instruction through IF/ID/EX/MEM/WB.
//  Write, read and PC strobes are gated by state; MEM waits a programmable number of cycles.
//  Decodes memory vs I/O from ALU_result_high and counts retired instructions.
//  Sits between the IR/iFetch and the register file, ALU, data memory and I/O bus.
// PARAMETERS
//  MEM_WAIT  1         extra MEM-state cycles per lw/sw (0..15); access lasts MEM_WAIT+1 cycles
//  IO_HIGH   22'h3FFFFF  ALU_result[31:10] value that selects I/O instead of memory
//  CNT_W     32        width of the retired-instruction counter
// PORTS
//  clock            in   1   system clock, rising edge
//  rst_n            in   1   asynchronous, active-low reset
//  Opcode           in   6   IR[31:26]; held stable by IR outside IF
//  Function_opcode  in   6   IR[5:0]
//  ALU_result_high  in   22  ALU_result[31:10]; valid in MEM
//  mem_stall        in   1   1 = extend MEM by one cycle (external bus busy)
//  Jr,Jmp,Jal,Branch,nBranch,RegDST,ALUSrc,I_format,Sftmd  out 1  level decodes, combinational from IR
//  ALUOp            out  2   {R_format|I_format, Branch|nBranch}
//  MemtoReg         out  1   1 for lw (level)
//  IRWrite          out  1   load IR; high only in IF
//  PCWrite          out  1   update PC; one-cycle pulse in the final cycle of each instruction
//  RegWrite         out  1   regfile write strobe; WB only
//  MemRead,MemWrite out  1   data-memory strobes; MEM only, address not I/O
//  IORead,IOWrite   out  1   I/O strobes; MEM only, ALU_result_high==IO_HIGH
//  state            out  3   IF=0 ID=1 EX=2 MEM=3 WB=4
//  instr_count      out CNT_W  instructions retired (PCWrite pulses) since reset
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IF, wait counter=0, instr_count=0. All strobes are low from the
//   cycle after release; IRWrite goes high in the first IF. Decode outputs stay combinational.
//  Decodes: lw=100011, sw=101011, R=000000, I_format=Opcode[5:3]==001,
//   Jr = R & funct==001000, j=000010, jal=000011, beq=000100, bne=000101.
//   Sftmd = R & funct in {00,02,03,04,06,07}; ALUSrc = I_format|lw|sw; RegDST = R.
//  Transitions (one cycle per state unless stated):
//   IF  -> ID always.
//   ID  -> IF with PCWrite for j and Jr; -> WB for jal; -> IF with PCWrite for an unrecognised opcode (NOP);
//          otherwise -> EX.
//   EX  -> IF with PCWrite for beq/bne; -> MEM for lw/sw; -> WB for R and I_format.
//   MEM: wait counter loads MEM_WAIT on entry and decrements while mem_stall=0; it holds while mem_stall=1.
//          The read/write strobe is high for every MEM cycle.
//          Exit when counter==0 & mem_stall==0: sw -> IF with PCWrite; lw -> WB.
//   WB  -> IF with RegWrite=1 and PCWrite=1 in the same cycle.
//  RegWrite is never asserted for Jr, even though Jr is R-format.
//  Exactly one of MemRead/IORead (lw) or MemWrite/IOWrite (sw) is high in MEM.
//  The memory/I-O choice is re-evaluated every MEM cycle from ALU_result_high.
//  instr_count increments on each PCWrite cycle and wraps modulo 2^CNT_W.
//  CPI: R/I 4; lw 5+MEM_WAIT; sw 4+MEM_WAIT; beq/bne 3; j/jr 2; jal 3.
//   Each mem_stall cycle adds 1 to lw/sw.
//  rst_n asserted mid-instruction aborts it: no strobe fires after the reset edge and the count does not
//   increment.
// TESTING
//  1. Reset, R-type add (000000/100000) -> states 0,1,2,4,0; RegWrite and PCWrite high in the WB cycle only;
//     instr_count=1.
//  2. lw to 0x0000_0040, MEM_WAIT=1 -> MemRead high 2 cycles, MemtoReg=1, then WB; total 6 cycles;
//     IORead stays 0.
//  3. sw with ALU_result_high=22'h3FFFFF, mem_stall high 2 cycles -> IOWrite high 4 cycles,
//     MemWrite=0, PCWrite on exit.
//  4. beq -> states 0,1,2, then PCWrite; RegWrite never high. jr (000000/001000) -> states 0,1; RegWrite=0.
//  5. jal -> states 0,1,4; RegWrite=1 and Jal=1 in WB; instr_count +1.
//  6. rst_n low during MEM of sw -> async return to IF, MemWrite drops immediately, instr_count=0;
//     illegal opcode 111111 -> 2-cycle NOP.

Source files
------------

// File: rtl/multicycle_control32.sv
// multicycle_control32: multi-cycle MIPS control, decodes the IR and sequences IF/ID/EX/MEM/WB
// with state-gated strobes, programmable MEM wait, memory/I-O select and a retired-instruction count.
module multicycle_control32 #(
  parameter int          MEM_WAIT = 1,
  parameter logic [21:0] IO_HIGH  = 22'h3FFFFF,
  parameter int          CNT_W    = 32
) (
  input  logic             clock_i,
  input  logic             rst_n_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       function_opcode_i,
  input  logic [21:0]      alu_result_high_i,
  input  logic             mem_stall_i,
  output logic             jr_o,
  output logic             jmp_o,
  output logic             jal_o,
  output logic             branch_o,
  output logic             nbranch_o,
  output logic             reg_dst_o,
  output logic             alu_src_o,
  output logic             i_format_o,
  output logic             sftmd_o,
  output logic [1:0]       alu_op_o,
  output logic             mem_to_reg_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             reg_write_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             io_read_o,
  output logic             io_write_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instr_count_o
);
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
  state_t           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             r_fmt, lw, sw, nop, io, in_mem, pc_write;
  assign r_fmt        = opcode_i == 6'b000000;
  assign lw           = opcode_i == 6'b100011;
  assign sw           = opcode_i == 6'b101011;
  assign jmp_o        = opcode_i == 6'b000010;
  assign jal_o        = opcode_i == 6'b000011;
  assign branch_o     = opcode_i == 6'b000100;
  assign nbranch_o    = opcode_i == 6'b000101;
  assign i_format_o   = opcode_i[5:3] == 3'b001;
  assign jr_o         = r_fmt & (function_opcode_i == 6'b001000);
  assign sftmd_o      = r_fmt & (function_opcode_i inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07});
  assign alu_src_o    = i_format_o | lw | sw;
  assign reg_dst_o    = r_fmt;
  assign alu_op_o     = {r_fmt | i_format_o, branch_o | nbranch_o};
  assign mem_to_reg_o = lw;
  // Anything not decoded retires as a two-cycle NOP from ID.
  assign nop = ~(r_fmt | i_format_o | lw | sw | jmp_o | jal_o | branch_o | nbranch_o);
  assign io  = alu_result_high_i == IO_HIGH;
  assign in_mem = state_q == S_MEM;
  assign ir_write_o    = state_q == S_IF;
  assign reg_write_o   = state_q == S_WB;
  assign mem_read_o    = in_mem & lw & ~io;
  assign mem_write_o   = in_mem & sw & ~io;
  assign io_read_o     = in_mem & lw & io;
  assign io_write_o    = in_mem & sw & io;
  assign pc_write_o    = pc_write;
  assign state_o       = state_q;
  assign instr_count_o = cnt_q;
  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IF;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    pc_write = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        pc_write = jmp_o | jr_o | nop;
        state_d  = pc_write ? S_IF : (jal_o ? S_WB : S_EX);
      end
      S_EX: begin
        pc_write = branch_o | nbranch_o;
        state_d  = pc_write ? S_IF : ((lw | sw) ? S_MEM : S_WB);
        wait_d   = 4'(MEM_WAIT);
      end
      S_MEM: begin
        if (wait_q == 4'd0 && !mem_stall_i) begin
          state_d  = lw ? S_WB : S_IF;
          pc_write = ~lw;
        end else if (!mem_stall_i) begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_WB: begin
        state_d  = S_IF;
        pc_write = 1'b1;
      end
      default: state_d = S_IF;
    endcase
    cnt_d = pc_write ? cnt_q + 1'b1 : cnt_q;
  end
endmodule
